pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It produces the enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, interlocks HI/LO readers and new mult/div ops against a multi-cycle mult/div unit, and squashes wrong-path and faulting instructions on taken branches and arithmetic overflow. It sits beside the pipeline registers and drives their enable/flush inputs; the EX/MEM register consumes `ex_mem_flush` as a bubble insert.

## Interface
- `MULT_LAT`, 4: mult/multu occupancy in cycles, range 1..63.
- `DIV_LAT`, 32: div/divu occupancy in cycles, range 1..63.
- `CNT_W`, 6: occupancy counter width.
- `clk` in 1: single clock. All state updates on the falling edge, the same edge the pipeline registers sample.
- `rst` in 1: synchronous reset, active-high, sampled on the same edge.
- `id_rs`, `id_rt` in 5: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction actually reads rs/rt.
- `id_is_mfhilo` in 1: ID instruction is mfhi/mflo.
- `id_is_multdiv` in 1: ID instruction is mult/multu/div/divu.
- `id_is_div` in 1: qualifies `id_is_multdiv`; 1 = div, 0 = mult.
- `ex_mem_read` in 1: instruction in EX is a load.
- `ex_rw` in 5: destination register of the EX instruction.
- `ex_branch_taken` in 1: branch/jump resolved taken in EX.
- `ex_overflow` in 1: arithmetic overflow in EX.
- `pc_en` out 1: PC load enable.
- `if_id_en` out 1: IF/ID load enable.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush` out 1: insert a bubble (all-zero) into that register at the next edge.
- `exc_pc_sel` out 1: PC mux selects the exception vector.
- `md_start` out 1: one-cycle start pulse to the mult/div unit.
- `md_busy` out 1: mult/div unit is occupied.
- `md_done` out 1: one-cycle pulse in the last busy cycle.
- `stall_cnt` out 32: count of cycles in which `pc_en` = 0.

## Operation
- State is one of two values: IDLE or BUSY. The block also holds `cnt` [CNT_W] and the `stall_cnt` register.
- **Load-use hazard (lu):** `ex_mem_read` && `ex_rw` != 0 && ((`id_uses_rs` && `id_rs` == `ex_rw`) || (`id_uses_rt` && `id_rt` == `ex_rw`)).
- **Mult/div hazard (md):** state BUSY && (`id_is_mfhilo` || `id_is_multdiv`).
- **Stall:** `stall` = (lu || md). On stall, `pc_en` = 0, `if_id_en` = 0 and `id_ex_flush` = 1. Outputs are combinational from inputs and state.
- **Start:** `md_start` = `id_is_multdiv` && !`stall` && !`ex_branch_taken` && !`ex_overflow` && state IDLE.
  - On the edge after a start, the state goes to BUSY.
  - `cnt` loads `DIV_LAT`-1 when `id_is_div` is set, else `MULT_LAT`-1.
- **BUSY:**
  - `cnt` decrements each edge.
  - When `cnt` == 0, `md_done` = 1 and the next state is IDLE.
  - `md_busy` = (state == BUSY).
  - An instruction waiting in ID issues in the cycle after `md_done`. For mfhi/mflo, HI/LO is valid at that point.
- **Taken branch (overrides stall):**
  - `pc_en` = 1, `if_id_en` = 1.
  - `if_id_flush` = 1 and `id_ex_flush` = 1.
- **Overflow (highest priority):**
  - `pc_en` = 1, `exc_pc_sel` = 1.
  - `if_id_flush` = 1, `id_ex_flush` = 1, `ex_mem_flush` = 1.
  - An in-flight mult/div is older than the faulting instruction and continues to completion.
- **Priority:** overflow > branch > stall > normal.
- **Normal operation:** `pc_en` = `if_id_en` = 1 and all flushes are 0.
- **Stall counter:** `stall_cnt` increments when `pc_en` = 0 and wraps modulo 2^32.

## Timing
- Hazard outputs have zero latency: they are combinational in the same cycle as the hazard inputs.
- Load-use costs exactly 1 stall cycle. The load advances to MEM and `ex_mem_read` drops.
- A mult started at edge E holds BUSY for `MULT_LAT` cycles. A dependent mfhi sees `md_busy` = 0 `MULT_LAT` cycles after E.
- Simultaneous lu and md stalls produce one stall and are counted once in `stall_cnt`.
- `md_start` is never asserted in BUSY. A mult/div in ID waits through the whole occupancy.
- Reset, including mid-BUSY: the next edge gives state IDLE, `cnt` = 0, `stall_cnt` = 0.
- Reset output values are:
  - `pc_en` = `if_id_en` = 1.
  - Flushes, `exc_pc_sel`, `md_start`, `md_busy` and `md_done` all 0.
  - `stall_cnt` = 0.
- `MULT_LAT` = 1: BUSY lasts a single cycle, with `md_done` in that same cycle.

## Structure
- Package `pipe_ctrl_pkg` holds the state encoding (IDLE = 0, BUSY = 1) and the default latency constants `MULT_LAT_DEF` = 4 and `DIV_LAT_DEF` = 32.
- Sub-module `md_timer` holds the BUSY state, the `cnt` down-counter, and the `md_busy`/`md_done` generation.
  - Its inputs are `clk`, `rst`, `start` and `is_div`.
  - The top level holds the hazard compare logic, the priority mux and `stall_cnt`.

## Test plan
- **Load-use:** load `$5` in EX (`ex_mem_read` = 1, `ex_rw` = 5) with `id_rs` = 5, `id_uses_rs` = 1 -> one cycle of `pc_en` = 0, `id_ex_flush` = 1; `stall_cnt` = 1. Repeat with `ex_rw` = 0 -> no stall.
- **Mult then mfhi:** mult in ID, then mfhi in ID the next cycle -> `md_start` pulse, then 4 stall cycles; `md_done` in the 4th; mfhi issues in the 5th; `stall_cnt` = 4.
- **Div then mult:** div then mult back-to-back -> mult stalls 32 cycles; a second `md_start` comes the cycle after `md_done`, with `cnt` loaded to 3.
- **Branch during stall:** `ex_branch_taken` during an md stall -> `pc_en` = 1, `if_id_flush` = `id_ex_flush` = 1; BUSY continues.
- **Overflow with mult in ID:** `ex_overflow` with a mult in ID -> `exc_pc_sel` = 1, all three flushes = 1, `md_start` = 0.
- **Reset mid-divide:** `rst` asserted 10 cycles into a div -> next edge `md_busy` = 0, `stall_cnt` = 0, `pc_en` = 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default mult/div latencies. Rev 1.0
`default_nettype none
package pipe_ctrl_pkg;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;
endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side hazard inputs and stage enable/flush outputs. Rev 1.0
`default_nettype none
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_mfhilo;
  logic        id_is_multdiv;
  logic        id_is_div;
  logic        ex_mem_read;
  logic [4:0]  ex_rw;
  logic        ex_branch_taken;
  logic        ex_overflow;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        exc_pc_sel;
  logic        md_start;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mfhilo, id_is_multdiv,
           id_is_div, ex_mem_read, ex_rw, ex_branch_taken, ex_overflow,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, exc_pc_sel,
           md_start, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mfhilo, id_is_multdiv,
           id_is_div, ex_mem_read, ex_rw, ex_branch_taken, ex_overflow,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, exc_pc_sel,
           md_start, md_busy, md_done, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// md_timer: mult/div occupancy tracker (IDLE/BUSY plus down-counter). Rev 1.0
`default_nettype none
module md_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic start,
  input  wire logic is_div,
  output logic      md_busy,
  output logic      md_done
);
  localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;

  // Pipeline registers sample on the falling edge, so this state does too.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_BUSY;
            r_cnt   <= is_div ? c_DIV_LOAD : c_MULT_LOAD;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - c_ONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign md_busy = (r_state == ST_BUSY);
  assign md_done = md_busy && (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / mult-div interlock and branch/overflow squash control. Rev 1.0
`default_nettype none
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input wire logic          clk,
  input wire logic          rst,
  pipe_hazard_ctrl_if.slave bus
);
  logic        w_lu;
  logic        w_md;
  logic        w_stall;
  logic        w_busy;
  logic        w_done;
  logic        w_pc_en;
  logic [31:0] r_stall_cnt;

  md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.md_start),
    .is_div  (bus.id_is_div),
    .md_busy (w_busy),
    .md_done (w_done)
  );

  // Register $0 is hardwired, so a load targeting it never creates a dependency.
  assign w_lu = bus.ex_mem_read && (bus.ex_rw != 5'd0) &&
                ((bus.id_uses_rs && (bus.id_rs == bus.ex_rw)) ||
                 (bus.id_uses_rt && (bus.id_rt == bus.ex_rw)));
  assign w_md    = w_busy && (bus.id_is_mfhilo || bus.id_is_multdiv);
  assign w_stall = w_lu || w_md;

  always_comb begin
    w_pc_en          = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.exc_pc_sel   = 1'b0;
    if (bus.ex_overflow) begin
      bus.exc_pc_sel   = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (w_stall) begin
      w_pc_en         = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

  // A mult/div being squashed or held in ID must not occupy the unit.
  assign bus.md_start = bus.id_is_multdiv && !w_stall && !bus.ex_branch_taken &&
                        !bus.ex_overflow && !w_busy;

  always_ff @(negedge clk) begin
    if (rst)           r_stall_cnt <= '0;
    else if (!w_pc_en) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign bus.pc_en     = w_pc_en;
  assign bus.md_busy   = w_busy;
  assign bus.md_done   = w_done;
  assign bus.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed multi-cycle sequences and random run vs. reference model.
`default_nettype none
module tb_pipe_hazard_ctrl;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of mult/div occupancy left, and the stall total.
  int          m_rem;
  logic [31:0] m_scnt;

  // DUT outputs captured on the rising edge, mid-cycle.
  logic        s_pc, s_ifen, s_iff, s_idf, s_emf, s_exc, s_start, s_busy, s_done;
  logic [31:0] s_scnt;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mfhilo, md, isdiv, memrd;
    logic [4:0] rw;
    logic       br, ovf;
    logic [6:0] exp;  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, exc_pc_sel, md_start}
  } vec_t;

  vec_t vecs[13];

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic mfhilo, input logic md, input logic isdiv, input logic memrd,
                        input logic [4:0] rw, input logic br, input logic ovf);
    bus.id_rs = rs;  bus.id_rt = rt;  bus.id_uses_rs = urs;  bus.id_uses_rt = urt;
    bus.id_is_mfhilo = mfhilo;  bus.id_is_multdiv = md;  bus.id_is_div = isdiv;
    bus.ex_mem_read = memrd;  bus.ex_rw = rw;  bus.ex_branch_taken = br;  bus.ex_overflow = ovf;
  endtask

  task automatic quiet();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic cycle(input bit use_model);
    logic e_pc, e_ifen, e_iff, e_idf, e_emf, e_exc, e_start, e_busy, e_done;
    bit   hz;
    @(posedge clk);
    s_pc = bus.pc_en;  s_ifen = bus.if_id_en;  s_iff = bus.if_id_flush;
    s_idf = bus.id_ex_flush;  s_emf = bus.ex_mem_flush;  s_exc = bus.exc_pc_sel;
    s_start = bus.md_start;  s_busy = bus.md_busy;  s_done = bus.md_done;  s_scnt = bus.stall_cnt;

    hz = (bus.ex_mem_read && bus.ex_rw != 0 &&
          ((bus.id_uses_rs && bus.id_rs == bus.ex_rw) || (bus.id_uses_rt && bus.id_rt == bus.ex_rw))) ||
         (m_rem > 0 && (bus.id_is_mfhilo || bus.id_is_multdiv));
    e_busy = (m_rem > 0);
    e_done = (m_rem == 1);
    if (bus.ex_overflow)          {e_pc, e_ifen, e_iff, e_idf, e_emf, e_exc} = 6'b111111;
    else if (bus.ex_branch_taken) {e_pc, e_ifen, e_iff, e_idf, e_emf, e_exc} = 6'b111100;
    else if (hz)                  {e_pc, e_ifen, e_iff, e_idf, e_emf, e_exc} = 6'b000100;
    else                          {e_pc, e_ifen, e_iff, e_idf, e_emf, e_exc} = 6'b110000;
    e_start = bus.id_is_multdiv && !hz && !bus.ex_branch_taken && !bus.ex_overflow && m_rem == 0;

    if (use_model) begin
      chk1("rnd pc_en", s_pc, e_pc);
      chk1("rnd if_id_en", s_ifen, e_ifen);
      chk1("rnd if_id_flush", s_iff, e_iff);
      chk1("rnd id_ex_flush", s_idf, e_idf);
      chk1("rnd ex_mem_flush", s_emf, e_emf);
      chk1("rnd exc_pc_sel", s_exc, e_exc);
      chk1("rnd md_start", s_start, e_start);
      chk1("rnd md_busy", s_busy, e_busy);
      chk1("rnd md_done", s_done, e_done);
      chk32("rnd stall_cnt", s_scnt, m_scnt);
    end

    if (rst) begin
      m_rem  = 0;
      m_scnt = 0;
    end else begin
      if (e_start)        m_rem = bus.id_is_div ? DIV_LAT : MULT_LAT;
      else if (m_rem > 0) m_rem--;
      if (!e_pc) m_scnt++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    cycle(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    m_rem  = 0;
    m_scnt = 0;
    quiet();

    //            rs     rt     urs  urt  mfhl md   div  memrd rw    br   ovf   expected
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b1100000};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 7'b0001000};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 7'b1100000};
    vecs[3]  = '{5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 7'b0001000};
    vecs[4]  = '{5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 7'b1100000};
    vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 7'b1111000};
    vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 7'b1111110};
    vecs[7]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b1100001};
    vecs[8]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 7'b0001000};
    vecs[9]  = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 7'b1111000};
    vecs[10] = '{5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 7'b1111110};
    vecs[11] = '{5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 7'b1100000};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 7'b1100000};

    // Reset values
    do_reset();
    cycle(1'b0);
    chk1("reset pc_en", s_pc, 1'b1);
    chk1("reset if_id_en", s_ifen, 1'b1);
    chk32("reset flags", 32'({s_iff, s_idf, s_emf, s_exc, s_start, s_busy, s_done}), 32'd0);
    chk32("reset stall_cnt", s_scnt, 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].mfhilo, vecs[i].md,
             vecs[i].isdiv, vecs[i].memrd, vecs[i].rw, vecs[i].br, vecs[i].ovf);
      cycle(1'b0);
      chk32($sformatf("vec%0d outputs", i),
            32'({s_pc, s_ifen, s_iff, s_idf, s_emf, s_exc, s_start}), 32'(vecs[i].exp));
    end

    // Load-use: one stall cycle, then $0 destination never stalls
    do_reset();
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    cycle(1'b0);
    chk1("lu pc_en", s_pc, 1'b0);
    chk1("lu id_ex_flush", s_idf, 1'b1);
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b0);
    cycle(1'b0);
    chk1("lu resume pc_en", s_pc, 1'b1);
    chk32("lu stall_cnt", s_scnt, 32'd1);
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    cycle(1'b0);
    chk1("lu r0 pc_en", s_pc, 1'b1);
    quiet();
    cycle(1'b0);
    chk32("lu r0 stall_cnt", s_scnt, 32'd1);

    // Mult then mfhi
    do_reset();
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0);
    chk1("mult start", s_start, 1'b1);
    chk1("mult busy before", s_busy, 1'b0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i <= MULT_LAT; i++) begin
      cycle(1'b0);
      chk1($sformatf("mfhi stall c%0d pc_en", i), s_pc, 1'b0);
      chk1($sformatf("mfhi stall c%0d busy", i), s_busy, 1'b1);
      chk1($sformatf("mfhi stall c%0d done", i), s_done, i == MULT_LAT);
    end
    cycle(1'b0);
    chk1("mfhi issue pc_en", s_pc, 1'b1);
    chk1("mfhi issue busy", s_busy, 1'b0);
    quiet();
    cycle(1'b0);
    chk32("mfhi stall_cnt", s_scnt, 32'd4);

    // Div then mult back-to-back
    do_reset();
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0);
    chk1("div start", s_start, 1'b1);
    set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i <= DIV_LAT; i++) begin
      cycle(1'b0);
      chk1($sformatf("div wait c%0d pc_en", i), s_pc, 1'b0);
      chk1($sformatf("div wait c%0d start", i), s_start, 1'b0);
      chk1($sformatf("div wait c%0d done", i), s_done, i == DIV_LAT);
    end
    cycle(1'b0);
    chk1("mult after div start", s_start, 1'b1);
    quiet();
    for (int i = 1; i <= MULT_LAT; i++) begin
      cycle(1'b0);
      chk1($sformatf("mult2 c%0d busy", i), s_busy, 1'b1);
      chk1($sformatf("mult2 c%0d done", i), s_done, i == MULT_LAT);
    end
    cycle(1'b0);
    chk1("mult2 idle", s_busy, 1'b0);
    chk32("div-mult stall_cnt", s_scnt, 32'(DIV_LAT));

    // Taken branch during an md stall
    do_reset();
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0);
    chk1("br pc_en", s_pc, 1'b1);
    chk1("br if_id_en", s_ifen, 1'b1);
    chk1("br if_id_flush", s_iff, 1'b1);
    chk1("br id_ex_flush", s_idf, 1'b1);
    chk1("br busy", s_busy, 1'b1);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0);
    chk1("br after pc_en", s_pc, 1'b0);
    chk1("br after busy", s_busy, 1'b1);

    // Reset in the middle of a divide
    do_reset();
    set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0);
    chk32("middiv stall_cnt", s_scnt, 32'd9);
    do_reset();
    quiet();
    cycle(1'b0);
    chk1("rst middiv busy", s_busy, 1'b0);
    chk1("rst middiv pc_en", s_pc, 1'b1);
    chk32("rst middiv stall_cnt", s_scnt, 32'd0);

    // Randomized run against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 19) == 0));
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
